// File: rtl/twos_pkg.sv
// Shared types and constants for the serial two's complement deserializer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package twos_pkg;

  // Default word length in bits.
  localparam int TWOS_WIDTH_DEF = 8;

  // Frame reception state.
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/twos_cell.sv
// Serial negation cell: passes bits through until the first 1 has been seen, then inverts.
// Latency: combinational decode; the seen_one flag updates on the rising edge.
// Backpressure: none; clr restarts the flag with the current bit as bit 0 of a word.
module twos_cell (
  input  logic clk,
  input  logic r_n,
  input  logic clr,
  input  logic i,
  output logic dec
);

  logic seen_one_q;
  logic seen_one_d;

  // Bit 0 always passes unchanged; later bits invert once any 1 has gone by.
  always_comb begin
    if (clr) begin
      dec        = i;
      seen_one_d = i;
    end else begin
      dec        = seen_one_q ? ~i : i;
      seen_one_d = seen_one_q | i;
    end
  end

  // Flag register, cleared by reset.
  always_ff @(posedge clk or negedge r_n) begin
    if (!r_n) begin
      seen_one_q <= 1'b0;
    end else begin
      seen_one_q <= seen_one_d;
    end
  end

endmodule

// File: rtl/serial_twos_deser.sv
// Deserializes an LSB-first serial word and outputs its two's complement (optional ovf via TWOS_OVF_EN).
// Latency: y/valid load on the edge sampling the last bit, visible the following cycle.
// Backpressure: none; start mid-frame aborts and restarts, back-to-back frames need no gap.
module serial_twos_deser
  import twos_pkg::*;
#(
  parameter int WIDTH = TWOS_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             r_n,
  input  logic             i,
  input  logic             start,
  output logic [WIDTH-1:0] y,
  output logic             valid,
  output logic             busy
`ifdef TWOS_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-2:0] sr_q, sr_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             valid_q, valid_d;
  logic             cell_i;
  logic             dec;
  logic [WIDTH-1:0] word;
`ifdef TWOS_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  // Feed the cell zero while idle so its flag does not move between frames.
  assign cell_i = (start || (state_q == SHIFT)) ? i : 1'b0;

  twos_cell u_cell (
    .clk (clk),
    .r_n (r_n),
    .clr (start),
    .i   (cell_i),
    .dec (dec)
  );

  // Word as it stands once the current decoded bit lands in the MSB position.
  assign word = {dec, sr_q};

  // Frame sequencing: start always opens a new frame, the last bit publishes the word.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    sr_d    = sr_q;
    y_d     = y_q;
    valid_d = 1'b0;
`ifdef TWOS_OVF_EN
    ovf_d   = ovf_q;
`endif
    if (start) begin
      state_d          = SHIFT;
      count_d          = CW'(1);
      sr_d             = '0;
      sr_d[WIDTH-2]    = dec;
    end else if (state_q == SHIFT) begin
      sr_d = word[WIDTH-1:1];
      if (count_q == LAST) begin
        state_d = IDLE;
        count_d = '0;
        y_d     = word;
        valid_d = 1'b1;
`ifdef TWOS_OVF_EN
        // Negation is a bijection with fixed points 0 and the most negative value,
        // so the decoded word equals 1000..0 exactly when the raw word did.
        ovf_d   = (word == {1'b1, {(WIDTH-1){1'b0}}});
`endif
      end else begin
        count_d = count_q + CW'(1);
      end
    end
  end

  // State and output registers; reset discards any partial frame.
  always_ff @(posedge clk or negedge r_n) begin
    if (!r_n) begin
      state_q <= IDLE;
      count_q <= '0;
      sr_q    <= '0;
      y_q     <= '0;
      valid_q <= 1'b0;
`ifdef TWOS_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      sr_q    <= sr_d;
      y_q     <= y_d;
      valid_q <= valid_d;
`ifdef TWOS_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign y     = y_q;
  assign valid = valid_q;
  assign busy  = (state_q == SHIFT);
`ifdef TWOS_OVF_EN
  assign ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_serial_twos_deser.sv
// Scoreboard bench for serial_twos_deser with directed and randomized frames.
// Latency: expects each word one cycle after its last bit is sampled.
// Backpressure: none; exercises aborts, resets and zero-gap frames.
module tb_serial_twos_deser;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         r_n = 1'b0;
  logic         i = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] y;
  logic         valid;
  logic         busy;
`ifdef TWOS_OVF_EN
  logic         ovf;
  logic         exp_ovf_q[$];
  logic         mon_ovf;
`endif

  int           n_checks = 0;
  int           n_fail = 0;
  int           cyc = 0;
  int           valid_cyc[$];
  logic [W-1:0] exp_y_q[$];
  logic [W-1:0] mon_y;

  serial_twos_deser #(.WIDTH(W)) dut (
    .clk   (clk),
    .r_n   (r_n),
    .i     (i),
    .start (start),
    .y     (y),
    .valid (valid),
    .busy  (busy)
`ifdef TWOS_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: arithmetic negation modulo 2^W.
  function automatic logic [W-1:0] ref_neg(input logic [W-1:0] raw);
    int m;
    int v;
    m = 1 << W;
    v = (m - int'(raw)) % m;
    return v[W-1:0];
  endfunction

  // Monitor: every valid pulse must match the oldest outstanding frame.
  always @(negedge clk) begin
    if (valid === 1'b1) begin
      valid_cyc.push_back(cyc);
      if (exp_y_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL spurious_valid: valid=1 with y=0x%0h, no frame outstanding", y);
      end else begin
        mon_y = exp_y_q.pop_front();
        chk("sb_y", 32'(y), 32'(mon_y));
`ifdef TWOS_OVF_EN
        mon_ovf = exp_ovf_q.pop_front();
        chk("sb_ovf", 32'(ovf), 32'(mon_ovf));
`endif
      end
    end
  end

  // Drive the first nbits of raw, LSB first, with start on bit 0.
  task automatic send_bits(input logic [W-1:0] raw, input int nbits);
    for (int k = 0; k < nbits; k++) begin
      @(negedge clk);
      start = (k == 0);
      i     = raw[k];
      if (k == W - 1) begin
        exp_y_q.push_back(ref_neg(raw));
`ifdef TWOS_OVF_EN
        exp_ovf_q.push_back(raw == W'(1 << (W - 1)));
`endif
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      start = 1'b0;
      i     = 1'($urandom);
    end
  endtask

  // Cycle after the last bit: valid high, busy low; one cycle later valid low.
  task automatic finish_check(input string tag);
    @(negedge clk);
    start = 1'b0;
    i     = 1'b0;
    chk({tag, "_busy_low"}, 32'(busy), 32'd0);
    chk({tag, "_valid_hi"}, 32'(valid), 32'd1);
    @(negedge clk);
    chk({tag, "_valid_one_cycle"}, 32'(valid), 32'd0);
  endtask

  initial begin
    int sz;
    logic [W-1:0] raw;

    // Reset state, with start asserted during reset that must be ignored.
    r_n   = 1'b0;
    start = 1'b1;
    i     = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_y", 32'(y), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
`ifdef TWOS_OVF_EN
    chk("rst_ovf", 32'(ovf), 32'd0);
`endif
    r_n   = 1'b1;
    start = 1'b0;
    idle(3);
    chk("post_rst_busy", 32'(busy), 32'd0);

    // Basic frames.
    send_bits(8'h05, W);
    finish_check("raw05");
    chk("raw05_y_held", 32'(y), 32'hFB);
    idle(2);
    send_bits(8'h00, W);
    finish_check("raw00");
    send_bits(8'h01, W);
    finish_check("raw01");
    chk("raw01_y_held", 32'(y), 32'hFF);

    // Most negative value then its neighbour.
    send_bits(8'h80, W);
    finish_check("raw80");
    send_bits(8'h7F, W);
    finish_check("raw7f");

    // Abort at bit 3 by re-asserting start, then a full frame.
    send_bits(8'hA5, 3);
    chk("mid_frame_busy", 32'(busy), 32'd1);
    send_bits(8'h02, W);
    finish_check("abort");
    chk("abort_y", 32'(y), 32'hFE);

    // Reset after 4 bits of a frame.
    send_bits(8'h3C, 4);
    @(negedge clk);
    start = 1'b0;
    r_n   = 1'b0;
    #1;
    chk("midrst_y", 32'(y), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    r_n = 1'b1;
    idle(4);
    chk("midrst_busy_after", 32'(busy), 32'd0);
    chk("midrst_y_after", 32'(y), 32'd0);

    // Back-to-back frames with zero gap.
    send_bits(8'hFF, W);
    send_bits(8'h10, W);
    finish_check("b2b");
    chk("b2b_y", 32'(y), 32'hF0);
    sz = valid_cyc.size();
    if (sz >= 2) begin
      chk("b2b_gap", 32'(valid_cyc[sz-1] - valid_cyc[sz-2]), 32'd8);
    end else begin
      n_checks++;
      n_fail++;
      $display("FAIL b2b_gap: saw %0d valid pulses, expected at least 2", sz);
    end

    // Randomized frames, aborts and gaps.
    for (int n = 0; n < 80; n++) begin
      raw = W'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        send_bits(W'($urandom), $urandom_range(1, W - 1));
      end
      send_bits(raw, W);
      idle($urandom_range(0, 2));
    end

    idle(4);
    chk("sb_drained", 32'(exp_y_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule

// File: doc/serial_twos_deser.md
SERIAL_TWOS_DESER -- requirements
Module: serial_twos_deser

Interface
REQ-001 Parameter: WIDTH, default 8, word length in bits (range 2..32).
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 r_n  input  1  reset, asynchronous, active-low.
REQ-004 i  input  1  serial data bit, LSB first, sampled every rising clk edge.
REQ-005 start  input  1  frame marker; high in the same cycle as bit 0 of a word.
REQ-006 y  output  WIDTH  recovered parallel word, the two's complement of the received serial word.
REQ-007 valid  output  1  one-cycle pulse: y holds a newly completed word.
REQ-008 busy  output  1  high while a frame is partially received.
REQ-009 ovf  output  1  overflow flag, present only when TWOS_OVF_EN is defined.

Function
REQ-010 FSM states: IDLE and SHIFT.
REQ-011 IDLE with start=0: i is ignored and no state changes.
REQ-012 IDLE with start=1: capture bit 0 unchanged, set seen_one=i, set count=1, and go to SHIFT.
REQ-013 SHIFT: each edge, the decoded bit = seen_one ? ~i : i; then seen_one |= i; count increments.
REQ-014 Decoded bits fill the shift register LSB first; after WIDTH bits, bit k of the word equals decoded bit k.
REQ-015 The edge that samples bit WIDTH-1 loads y with the full word, sets valid=1 for exactly one cycle, and returns to IDLE.
REQ-016 Latency: valid and y are updated at the edge that samples the last bit; they are visible in the following cycle.
REQ-017 y holds its value until the next completed frame; an aborted frame never changes y.
REQ-018 start=1 while in SHIFT aborts the current frame without a valid pulse; the sampled bit is taken as bit 0 of a new frame.
REQ-019 Back-to-back frames: start is accepted in the cycle immediately after the last bit, with zero gap; valid of the old frame and bit 0 of the new frame coincide.
REQ-020 busy = (state == SHIFT).
REQ-021 Count width is clog2(WIDTH); count never wraps beyond WIDTH-1.

Reset
REQ-022 While r_n=0: state=IDLE, count=0, seen_one=0, shift register=0, y=0, valid=0, busy=0, ovf=0.
REQ-023 Reset asserted mid-frame discards the partial word; no valid pulse follows reset release.
REQ-024 The first frame is accepted only on a start sampled at or after the first clk edge with r_n=1.

Configuration
REQ-025 Macro TWOS_OVF_EN defined: ovf is loaded together with y, set to 1 exactly when the raw word is 1 followed by WIDTH-1 zeros (most negative value, whose negation is unrepresentable), and held with y.
REQ-026 Macro TWOS_OVF_EN undefined: the ovf port and its logic are absent; all other behaviour is identical.

Structure
REQ-027 Package twos_pkg holds the FSM state enum (IDLE, SHIFT) and the constant TWOS_WIDTH_DEF=8.
REQ-028 Sub-module twos_cell holds the seen_one flag and its invert logic (inputs: clk, r_n, clr, i; output: decoded bit); it is instantiated once.

Verification (WIDTH=8)
REQ-029 Raw 0x05 (bits 1,0,1,0,0,0,0,0) with start on bit 0 -> y=0xFB, valid high for one cycle after the 8th bit, busy low afterwards.
REQ-030 Raw 0x00 -> y=0x00, valid pulse; raw 0x01 -> y=0xFF.
REQ-031 Raw 0x80 with TWOS_OVF_EN -> y=0x80, ovf=1; a following raw 0x7F -> y=0x81, ovf=0.
REQ-032 start re-asserted at bit 3, then raw 0x02 sent -> exactly one valid pulse, y=0xFE.
REQ-033 r_n pulsed low after 4 bits of a frame -> y=0x00, valid stays low, busy=0 until the next start.
REQ-034 Back-to-back raw 0xFF then 0x10 with no gap -> valid pulses 8 cycles apart, y=0x01 then y=0xF0.
